sr_chip_emulator: RTL and testbench

- Device-side responder for the serial configuration shift-register link: receives clk_sr/din_sr/load_sr and drives dout_sr, emulating the detector's WIDTH-bit configuration shift register and its load latch.
- Used in FPGA loopback builds and benches so the SR controller and receiver path can be exercised without silicon.
- Runs on one fast system clock and oversamples the slow link signals; exposes the latched configuration and a per-frame length check.

---
 rtl/sr_chip_emulator_pkg.sv | 14 +
 rtl/sr_sync_edge.sv | 35 +++
 rtl/sr_chip_emulator.sv | 136 +++++++++++++
 tb/tb_sr_chip_emulator.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sr_chip_emulator_pkg.sv
// Shared types and default sizes for the serial configuration shift-register link.
// The SR controller and receiver import the same defaults so all ends agree on frame length.
package sr_chip_emulator_pkg;

  localparam int unsigned SrWidth    = 170;
  localparam int unsigned SrCntWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } sr_state_e;

endpackage

// File: rtl/sr_sync_edge.sv
// Synchronizer chain plus rising-edge detector for one slow, asynchronous link input.
// Edges are suppressed until the chain and the edge history hold post-reset samples only.
module sr_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   arm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      // Fills with ones; the top bit is set once prev_q reflects a post-reset sample.
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_comb begin
    level = sync_q[SYNC_STAGES-1];
    rise  = arm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
  end

endmodule

// File: rtl/sr_chip_emulator.sv
// Device-side emulator of the detector configuration shift register and its load latch.
// Oversamples clk_sr/din_sr/load_sr on the system clock and reports per-frame length.
module sr_chip_emulator
  import sr_chip_emulator_pkg::*;
#(
  parameter int unsigned WIDTH       = SrWidth,
  parameter int unsigned CNT_WIDTH   = SrCntWidth,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_sr,
  input  logic                 din_sr,
  input  logic                 load_sr,
  output logic                 dout_sr,
  output logic [WIDTH-1:0]     cfg_out,
  output logic                 cfg_valid,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic                 len_err,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] CntMax   = '1;
  localparam logic [CNT_WIDTH-1:0] WidthCnt = CNT_WIDTH'(WIDTH);

  logic clk_level, clk_rise;
  logic din_level, din_rise;
  logic load_level, load_rise;

  sr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk      (clk),
    .rst      (rst),
    .async_in (clk_sr),
    .level    (clk_level),
    .rise     (clk_rise)
  );

  sr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk      (clk),
    .rst      (rst),
    .async_in (din_sr),
    .level    (din_level),
    .rise     (din_rise)
  );

  sr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk      (clk),
    .rst      (rst),
    .async_in (load_sr),
    .level    (load_level),
    .rise     (load_rise)
  );

  logic unused_sync;
  assign unused_sync = clk_level ^ din_rise ^ load_level;

  sr_state_e            state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [WIDTH-1:0]     cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_shifted;
  logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;
  logic                 len_err_q, len_err_d;
  logic                 dout_q;

  // Datapath: a shift in the same cycle as a load is applied before the latch.
  always_comb begin
    shreg_d     = shreg_q;
    cfg_d       = cfg_q;
    bit_count_d = bit_count_q;
    len_err_d   = len_err_q;
    cnt_shifted = cnt_q;

    if (clk_rise) begin
      shreg_d     = {shreg_q[WIDTH-2:0], din_level};
      cnt_shifted = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
    cnt_d = cnt_shifted;

    if (load_rise) begin
      cfg_d       = shreg_d;
      bit_count_d = cnt_shifted;
      len_err_d   = (cnt_shifted != WidthCnt);
      cnt_d       = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_rise)     state_d = StLatch;
        else if (clk_rise) state_d = StShift;
      end
      StShift: begin
        if (load_rise) state_d = StLatch;
      end
      StLatch: begin
        if (load_rise)     state_d = StLatch;
        else if (clk_rise) state_d = StShift;
        else               state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      cfg_q       <= '0;
      cnt_q       <= '0;
      bit_count_q <= '0;
      len_err_q   <= 1'b0;
      dout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      bit_count_q <= bit_count_d;
      len_err_q   <= len_err_d;
      dout_q      <= shreg_q[WIDTH-1];
    end
  end

  always_comb begin
    dout_sr   = dout_q;
    cfg_out   = cfg_q;
    cfg_valid = (state_q == StLatch);
    bit_count = bit_count_q;
    len_err   = len_err_q;
    busy      = (state_q == StShift);
  end

endmodule

// File: tb/tb_sr_chip_emulator.sv
// Directed bench for sr_chip_emulator: drives the slow link from the system clock domain
// and compares latched words, counts and readback against a small shift-register model.
module tb_sr_chip_emulator;

  localparam int unsigned W     = 170;
  localparam int unsigned CW    = 8;
  localparam int unsigned PHASE = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_sr = 1'b0;
  logic          din_sr = 1'b0;
  logic          load_sr = 1'b0;
  logic          dout_sr;
  logic [W-1:0]  cfg_out;
  logic          cfg_valid;
  logic [CW-1:0] bit_count;
  logic          len_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  logic [W-1:0] model_sr  = '0;
  int           model_cnt = 0;

  always #5 clk = ~clk;

  sr_chip_emulator #(
    .WIDTH       (W),
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_sr    (clk_sr),
    .din_sr    (din_sr),
    .load_sr   (load_sr),
    .dout_sr   (dout_sr),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .bit_count (bit_count),
    .len_err   (len_err),
    .busy      (busy)
  );

  always @(negedge clk) if (cfg_valid) vcount++;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_shift(input logic b);
    model_sr  = {model_sr[W-2:0], b};
    model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
  endtask

  // One link bit; rb is dout_sr just before the rising edge of clk_sr.
  task automatic send_bit(input logic b, output logic rb);
    din_sr = b;
    clk_sr = 1'b0;
    wait_clk(PHASE);
    rb     = dout_sr;
    clk_sr = 1'b1;
    wait_clk(PHASE);
    clk_sr = 1'b0;
    model_shift(b);
  endtask

  task automatic send_const(input int n, input logic b);
    logic rb;
    for (int i = 0; i < n; i++) send_bit(b, rb);
  endtask

  task automatic send_alt(input int n);
    logic rb;
    for (int i = 0; i < n; i++) send_bit(logic'(((i % 3) == 0) ? 1'b1 : 1'b0), rb);
  endtask

  task automatic check_latch(input string tag);
    check_eq({tag, ".cfg"}, 256'(cfg_out), 256'(model_sr));
    check_eq({tag, ".cnt"}, 256'(bit_count), 256'(model_cnt));
    check_eq({tag, ".lerr"}, 256'(len_err), 256'(model_cnt != W));
    check_eq({tag, ".vld"}, 256'(vcount), 256'(1));
    model_cnt = 0;
  endtask

  task automatic load_and_check(input string tag);
    vcount  = 0;
    load_sr = 1'b1;
    wait_clk(PHASE);
    load_sr = 1'b0;
    wait_clk(PHASE);
    check_latch(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".cfg"}, 256'(cfg_out), 256'(0));
    check_eq({tag, ".flags"}, 256'({dout_sr, cfg_valid, len_err, busy}), 256'(0));
    check_eq({tag, ".cnt"}, 256'(bit_count), 256'(0));
  endtask

  initial begin
    logic rb;
    int   ones;

    wait_clk(4);
    check_all_zero("reset");
    rst = 1'b0;
    wait_clk(6);

    // Zero-length load after reset
    load_and_check("zero_len");

    // Basic frame: bit i = i[0]^i[2]
    for (int i = 0; i < W; i++) begin
      send_bit(logic'(((i & 1) ^ ((i >> 2) & 1)) != 0), rb);
      if (i == 10) check_eq("busy_mid", 256'(busy), 256'(1));
    end
    load_and_check("basic");
    check_eq("busy_after", 256'(busy), 256'(0));

    // Readback: all ones latched, then zeros clock the ones back out
    send_const(W, 1'b1);
    load_and_check("frame_a");
    ones = 0;
    for (int i = 0; i < W; i++) begin
      send_bit(1'b0, rb);
      if (rb === 1'b1) ones++;
    end
    check_eq("readback_ones", 256'(ones), 256'(W));
    check_eq("readback_last", 256'(dout_sr), 256'(0));
    load_and_check("frame_b");

    // Short and long frames
    send_alt(W - 1);
    load_and_check("short");
    send_alt(300);
    load_and_check("long");
    check_eq("long_sat", 256'(bit_count), 256'(255));

    // Simultaneous clk_sr and load_sr rise on the 170th bit
    send_alt(W - 1);
    vcount  = 0;
    din_sr  = 1'b1;
    wait_clk(PHASE);
    clk_sr  = 1'b1;
    load_sr = 1'b1;
    wait_clk(PHASE);
    clk_sr  = 1'b0;
    load_sr = 1'b0;
    model_shift(1'b1);
    wait_clk(PHASE);
    check_latch("simul");
    check_eq("simul_idle", 256'(busy), 256'(0));

    // Reset mid-frame
    send_alt(80);
    rst = 1'b1;
    wait_clk(1);
    check_all_zero("mid_rst");
    rst       = 1'b0;
    model_sr  = '0;
    model_cnt = 0;
    wait_clk(6);
    for (int i = 0; i < W; i++) send_bit(logic'((i % 5) < 2), rb);
    load_and_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
